// File: rtl/pu_rf_wb_arb.sv
// Register-file write-port arbiter: shares one RF write port among the ALU,
// a small load-return buffer and a host config port. It also tracks pending
// loads in a scoreboard for decode-stage hazard detection.
module pu_rf_wb_arb #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned DEPTH_NBITS   = 5,
  parameter int unsigned LD_FIFO_DEPTH = 2,
  parameter int unsigned HOST_STARVE   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_wr,
  input  logic [DEPTH_NBITS-1:0] alu_waddr,
  input  logic [WIDTH-1:0]       alu_din,
  input  logic                   ld_issue,
  input  logic [DEPTH_NBITS-1:0] ld_issue_waddr,
  input  logic                   ld_rsp_valid,
  output logic                   ld_rsp_ready,
  input  logic [DEPTH_NBITS-1:0] ld_rsp_waddr,
  input  logic [WIDTH-1:0]       ld_rsp_data,
  input  logic                   host_wr_valid,
  output logic                   host_wr_ready,
  input  logic [DEPTH_NBITS-1:0] host_waddr,
  input  logic [WIDTH-1:0]       host_wdata,
  input  logic [DEPTH_NBITS-1:0] rd_addr0,
  input  logic [DEPTH_NBITS-1:0] rd_addr1,
  output logic                   hazard,
  output logic                   rf_wr,
  output logic [DEPTH_NBITS-1:0] rf_waddr,
  output logic [WIDTH-1:0]       rf_din,
  output logic                   sb_err
);

  localparam int unsigned NREGS = 1 << DEPTH_NBITS;
  localparam int unsigned PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(LD_FIFO_DEPTH + 1);
  localparam int unsigned STV_W = (HOST_STARVE > 0) ? $clog2(HOST_STARVE + 1) : 1;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_HOST,
    SRC_LD
  } src_e;

  logic [DEPTH_NBITS-1:0] fifo_waddr [LD_FIFO_DEPTH];
  logic [WIDTH-1:0]       fifo_data  [LD_FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [STV_W-1:0]       starve_cnt;
  logic [NREGS-1:0]       busy;
  logic [NREGS-1:0]       busy_set;
  logic [NREGS-1:0]       busy_clr;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   starved;
  logic                   push;
  logic                   pop;
  logic                   err_now;
  logic [DEPTH_NBITS-1:0] head_waddr;
  logic [WIDTH-1:0]       head_data;
  src_e                   src;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LD_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (count == CNT_W'(LD_FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign starved    = (starve_cnt == STV_W'(HOST_STARVE));
  assign head_waddr = fifo_waddr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  // Fixed-priority write-port selection with host anti-starvation override
  always_comb begin
    src = SRC_NONE;
    if (rst)                            src = SRC_NONE;
    else if (alu_wr)                    src = SRC_ALU;
    else if (host_wr_valid && starved)  src = SRC_HOST;
    else if (!fifo_empty)               src = SRC_LD;
    else if (host_wr_valid)             src = SRC_HOST;
  end

  assign ld_rsp_ready  = !fifo_full && !rst;
  assign host_wr_ready = (src == SRC_HOST);
  assign push          = ld_rsp_valid && ld_rsp_ready;
  assign pop           = (src == SRC_LD);
  assign hazard        = busy[rd_addr0] | busy[rd_addr1];

  // Scoreboard set/clear masks and write-after-write error detection
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (ld_issue) busy_set[ld_issue_waddr] = 1'b1;
    if (pop)      busy_clr[head_waddr]     = 1'b1;
    err_now = (ld_issue && busy[ld_issue_waddr] && !(pop && (head_waddr == ld_issue_waddr)))
           || (alu_wr && busy[alu_waddr])
           || ((src == SRC_HOST) && busy[host_waddr])
           || (pop && !busy[head_waddr]);
  end

  // Load-return buffer storage (contents need no reset; validity is in count)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_waddr[wr_ptr] <= ld_rsp_waddr;
      fifo_data[wr_ptr]  <= ld_rsp_data;
    end
  end

  // Load-return buffer pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Host starvation counter: counts cycles the host waits, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (host_wr_valid && (src != SRC_HOST)) begin
      if (!starved) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Busy vector; a same-cycle set wins over a clear of the same bit
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~busy_clr) | busy_set;
  end

  // Sticky scoreboard error flag
  always_ff @(posedge clk) begin
    if (rst)          sb_err <= 1'b0;
    else if (err_now) sb_err <= 1'b1;
  end

  // Registered RF write port; address/data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr    <= 1'b0;
      rf_waddr <= '0;
      rf_din   <= '0;
    end else begin
      rf_wr <= (src != SRC_NONE);
      case (src)
        SRC_ALU: begin
          rf_waddr <= alu_waddr;
          rf_din   <= alu_din;
        end
        SRC_HOST: begin
          rf_waddr <= host_waddr;
          rf_din   <= host_wdata;
        end
        SRC_LD: begin
          rf_waddr <= head_waddr;
          rf_din   <= head_data;
        end
        default: ;
      endcase
    end
  end

endmodule
